// File: rtl/bt_cmd_rx_if.sv
// Bus between the Bluetooth UART side and the command receiver.
//   rx             : UART line into the receiver (idle high)
//   rx_byte/valid  : last received byte and its 1-cycle strobe
//   frame_err      : 1-cycle pulse on a low stop bit
//   cmd_valid/err  : 1-cycle pulses for an accepted / rejected line
//   cmd_id, x, y   : last accepted command and its arguments
// master = line driver / observer side, slave = bt_cmd_rx.
interface bt_cmd_rx_if #(
  parameter int COORD_W = 7
);
  logic               rx;
  logic [7:0]         rx_byte;
  logic               rx_byte_valid;
  logic               frame_err;
  logic               cmd_valid;
  logic               cmd_err;
  logic [3:0]         cmd_id;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  modport master (
    output rx,
    input  rx_byte, rx_byte_valid, frame_err,
    input  cmd_valid, cmd_err, cmd_id, x, y
  );

  modport slave (
    input  rx,
    output rx_byte, rx_byte_valid, frame_err,
    output cmd_valid, cmd_err, cmd_id, x, y
  );
endinterface

// File: rtl/bt_cmd_rx.sv
// Bluetooth command receiver: UART byte receiver plus ASCII line parser.
// Accepts lines "CC,X,Y<term>" or "CC<term>" (term = CR, LF or CRLF) and
// turns them into command pulses for the paint core.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : bt_cmd_rx_if.slave (rx in; rx_byte, rx_byte_valid, frame_err,
//          cmd_valid, cmd_err, cmd_id, x, y out)
module bt_cmd_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int COORD_W    = 7,
  parameter int MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  bt_cmd_rx_if.slave  bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int ACC_W        = COORD_W + 4;
  localparam int NDIG_W       = $clog2(MAX_DIGITS + 2);
  localparam logic [ACC_W-1:0]  ACC_MAX  = ACC_W'((1 << COORD_W) - 1);
  localparam logic [NDIG_W-1:0] NDIG_MAX = NDIG_W'(MAX_DIGITS);

  // ---------------------------------------------------------------- UART
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;

  u_state_t         u_state, u_next;
  logic             rx_s1, rx_s2, rx_prev, armed;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       rx_byte_q;
  logic             rx_byte_valid_q, frame_err_q;
  logic             start_det, half_done, bit_done;

  assign start_det = armed && rx_prev && !rx_s2;
  assign half_done = (cnt == CNT_W'(HALF_BIT - 1));
  assign bit_done  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    u_next = u_state;
    unique case (u_state)
      U_IDLE:  if (start_det) u_next = U_START;
      U_START: if (half_done) u_next = rx_s2 ? U_IDLE : U_DATA;
      U_DATA:  if (bit_done && bit_idx == 3'd7) u_next = U_STOP;
      U_STOP:  if (bit_done) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) u_state <= U_IDLE;
    else     u_state <= u_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1           <= 1'b0;
      rx_s2           <= 1'b0;
      rx_prev         <= 1'b0;
      armed           <= 1'b0;
      cnt             <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      rx_s1           <= bus.rx;
      rx_s2           <= rx_s1;
      rx_prev         <= rx_s2;
      rx_byte_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
      // Only a line seen idle-high may start a byte; cleared on a bad stop.
      if (rx_s2) armed <= 1'b1;
      unique case (u_state)
        U_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        U_START: cnt <= half_done ? '0 : cnt + 1'b1;
        U_DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shift   <= {rx_s2, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (rx_s2) begin
              rx_byte_q       <= shift;
              rx_byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              armed       <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // -------------------------------------------------------------- parser
  typedef enum logic [2:0] {P_IDLE, P_CMD1, P_CMDEND, P_X, P_Y, P_SKIP} p_state_t;

  p_state_t           p_state, p_next;
  logic [7:0]         c0, c1, c0_n, c1_n;
  logic [ACC_W-1:0]   acc, acc_n, acc_dig;
  logic [NDIG_W-1:0]  ndig, ndig_n, ndig_inc;
  logic [COORD_W-1:0] xa, xa_n, emit_x, emit_y;
  logic               emit_ok, emit_err;
  logic [7:0]         ch;
  logic               is_letter, is_digit, is_term, is_comma, digit_ok;
  logic [3:0]         code;
  logic               cmd_valid_q, cmd_err_q;
  logic [3:0]         cmd_id_q;
  logic [COORD_W-1:0] x_q, y_q;

  function automatic logic [3:0] lookup(input logic [7:0] a, input logic [7:0] b);
    case ({a, b})
      "UP":    return 4'd1;
      "DN":    return 4'd2;
      "LT":    return 4'd3;
      "RT":    return 4'd4;
      "PX":    return 4'd5;
      "CL":    return 4'd6;
      "CO":    return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  assign ch        = (rx_byte_q >= 8'h61 && rx_byte_q <= 8'h7A) ? rx_byte_q - 8'h20 : rx_byte_q;
  assign is_letter = (ch >= 8'h41 && ch <= 8'h5A);
  assign is_digit  = (ch >= 8'h30 && ch <= 8'h39);
  assign is_term   = (ch == 8'h0D || ch == 8'h0A);
  assign is_comma  = (ch == 8'h2C);
  assign code      = lookup(c0, c1);
  assign acc_dig   = acc * ACC_W'(10) + ACC_W'(ch[3:0]);
  assign ndig_inc  = ndig + 1'b1;
  assign digit_ok  = (acc_dig <= ACC_MAX) && (ndig_inc <= NDIG_MAX);

  always_comb begin
    p_next   = p_state;
    c0_n     = c0;
    c1_n     = c1;
    acc_n    = acc;
    ndig_n   = ndig;
    xa_n     = xa;
    emit_ok  = 1'b0;
    emit_err = 1'b0;
    emit_x   = '0;
    emit_y   = '0;
    if (frame_err_q) begin
      p_next = P_SKIP;
    end else if (rx_byte_valid_q) begin
      // Unaccepted bytes fall through to these defaults: a terminator
      // rejects the line at once, anything else waits in P_SKIP.
      p_next   = is_term ? P_IDLE : P_SKIP;
      emit_err = is_term;
      unique case (p_state)
        P_IDLE: begin
          if (is_term) begin
            emit_err = 1'b0;
          end else if (is_letter) begin
            c0_n   = ch;
            p_next = P_CMD1;
          end
        end
        P_CMD1: begin
          if (is_letter) begin
            c1_n   = ch;
            p_next = P_CMDEND;
          end
        end
        P_CMDEND: begin
          if (is_comma) begin
            acc_n  = '0;
            ndig_n = '0;
            p_next = P_X;
          end else if (is_term && code != 4'd0) begin
            emit_ok  = 1'b1;
            emit_err = 1'b0;
          end
        end
        P_X: begin
          if (is_digit && digit_ok) begin
            acc_n  = acc_dig;
            ndig_n = ndig_inc;
            p_next = P_X;
          end else if (is_comma && ndig != '0) begin
            xa_n   = acc[COORD_W-1:0];
            acc_n  = '0;
            ndig_n = '0;
            p_next = P_Y;
          end
        end
        P_Y: begin
          if (is_digit && digit_ok) begin
            acc_n  = acc_dig;
            ndig_n = ndig_inc;
            p_next = P_Y;
          end else if (is_term && ndig != '0 && code != 4'd0) begin
            emit_ok  = 1'b1;
            emit_err = 1'b0;
            emit_x   = xa;
            emit_y   = acc[COORD_W-1:0];
          end
        end
        P_SKIP:  ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_state <= P_IDLE;
    else     p_state <= p_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0          <= '0;
      c1          <= '0;
      acc         <= '0;
      ndig        <= '0;
      xa          <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_id_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      c0          <= c0_n;
      c1          <= c1_n;
      acc         <= acc_n;
      ndig        <= ndig_n;
      xa          <= xa_n;
      cmd_valid_q <= emit_ok;
      cmd_err_q   <= emit_err;
      if (emit_ok) begin
        cmd_id_q <= code;
        x_q      <= emit_x;
        y_q      <= emit_y;
      end
    end
  end

  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_byte_valid = rx_byte_valid_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd_err       = cmd_err_q;
  assign bus.cmd_id        = cmd_id_q;
  assign bus.x             = x_q;
  assign bus.y             = y_q;
endmodule

// File: tb/tb_bt_cmd_rx.sv
module tb_bt_cmd_rx;
  localparam int CLK_FREQ   = 800_000;
  localparam int BAUD       = 100_000;
  localparam int CPB        = CLK_FREQ / BAUD;
  localparam int COORD_W    = 7;
  localparam int MAX_DIGITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bt_cmd_rx_if #(.COORD_W(COORD_W)) bus ();

  bt_cmd_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .COORD_W   (COORD_W),
    .MAX_DIGITS(MAX_DIGITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ------------------------------------------------ line-level reference
  typedef struct {
    bit ok;
    int id;
    int x;
    int y;
  } ev_t;

  ev_t              exp_ev[$];
  int               exp_byte[$];
  int               exp_fe = 0;
  logic [7:0]       lbuf[$];
  bit               line_bad = 0;

  function automatic int mn_id(logic [7:0] a, logic [7:0] b);
    case ({a, b})
      "UP": return 1;  "DN": return 2;  "LT": return 3;  "RT": return 4;
      "PX": return 5;  "CL": return 6;  "CO": return 7;
      default: return 0;
    endcase
  endfunction

  // Judge a complete line against the grammar LL or LL,D+,D+ .
  function automatic ev_t eval_line();
    ev_t e;
    int  n, i, k;
    int  v[2];
    e.ok = 0; e.id = 0; e.x = 0; e.y = 0;
    n = lbuf.size();
    if (line_bad || n < 2) return e;
    e.id = mn_id(lbuf[0], lbuf[1]);
    if (e.id == 0) return e;
    if (n == 2) begin
      e.ok = 1;
      return e;
    end
    i = 2;
    for (int f = 0; f < 2; f++) begin
      if (i >= n || lbuf[i] != 8'h2C) return e;
      i++;
      k = 0;
      v[f] = 0;
      while (i < n && lbuf[i] >= 8'h30 && lbuf[i] <= 8'h39) begin
        v[f] = v[f] * 10 + int'(lbuf[i] - 8'h30);
        k++;
        i++;
      end
      if (k < 1 || k > MAX_DIGITS || v[f] > (1 << COORD_W) - 1) return e;
    end
    if (i != n) return e;
    e.ok = 1; e.x = v[0]; e.y = v[1];
    return e;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit fe);
    logic [7:0] c;
    if (fe) begin
      exp_fe++;
      line_bad = 1;
      return;
    end
    exp_byte.push_back(int'(b));
    c = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    if (c == 8'h0D || c == 8'h0A) begin
      if (lbuf.size() != 0 || line_bad) exp_ev.push_back(eval_line());
      lbuf.delete();
      line_bad = 0;
    end else begin
      lbuf.push_back(c);
    end
  endtask

  // ---------------------------------------------------------- stimulus
  task automatic send_byte(input logic [7:0] b, input bit fe);
    model_byte(b, fe);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = !fe;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (fe ? 2 * CPB : int'($urandom_range(0, 3))) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  // term: 1 = CR, 2 = LF, 3 = CRLF
  task automatic send_line(input string s, input int term);
    send_str(s);
    if (term != 2) send_byte(8'h0D, 1'b0);
    if (term != 1) send_byte(8'h0A, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [15:0] pick_mn(int m);
    case (m)
      0: return "UP"; 1: return "DN"; 2: return "LT"; 3: return "RT";
      4: return "PX"; 5: return "CL"; 6: return "CO"; 7: return "ZZ";
      default: return "QA";
    endcase
  endfunction

  task automatic send_random_line();
    logic [7:0]  q[$];
    logic [15:0] mn;
    logic [7:0]  c;
    int          r, nd, val, p, fe_idx;
    mn = pick_mn(int'($urandom_range(0, 8)));
    for (int h = 1; h >= 0; h--) begin
      c = mn[h*8 +: 8];
      if ($urandom_range(0, 1) == 1) c = c | 8'h20;
      q.push_back(c);
    end
    if ($urandom_range(0, 4) != 0) begin
      for (int f = 0; f < 2; f++) begin
        q.push_back(($urandom_range(0, 11) == 0) ? 8'h3B : 8'h2C);
        r   = int'($urandom_range(0, 9));
        nd  = (r == 0) ? 0 : (r == 1) ? 4 : int'($urandom_range(1, 3));
        val = (nd <= 1) ? int'($urandom_range(0, 9)) :
              (nd == 2) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 160));
        p = 1;
        for (int k = 1; k < nd; k++) p *= 10;
        for (int k = 0; k < nd; k++) begin
          q.push_back(8'h30 + 8'((val / p) % 10));
          p /= 10;
        end
      end
    end
    r = int'($urandom_range(0, 2));
    if (r != 1) q.push_back(8'h0D);
    if (r != 0) q.push_back(8'h0A);
    fe_idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
    for (int i = 0; i < q.size(); i++) send_byte(q[i], i == fe_idx);
  endtask

  // ------------------------------------------------------ compare process
  int n_valid = 0, n_err = 0, n_fe = 0, n_bytes = 0;
  int m_id = 0, m_x = 0, m_y = 0;

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      m_id = 0; m_x = 0; m_y = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_err) chk("valid_and_err_together", 1, 0);
      if (bus.rx_byte_valid) begin
        n_bytes++;
        if (exp_byte.size() == 0) chk("unexpected_rx_byte", int'(bus.rx_byte), -1);
        else chk("rx_byte", int'(bus.rx_byte), exp_byte.pop_front());
      end
      if (bus.frame_err) begin
        n_fe++;
        chk("frame_err_expected", (exp_fe > 0) ? 1 : 0, 1);
        if (exp_fe > 0) exp_fe--;
      end
      if (bus.cmd_valid || bus.cmd_err) begin
        if (bus.cmd_valid) n_valid++;
        else n_err++;
        if (exp_ev.size() == 0) begin
          chk("unexpected_cmd_pulse", int'(bus.cmd_valid), -1);
        end else begin
          e = exp_ev.pop_front();
          chk("cmd_valid_vs_err", int'(bus.cmd_valid), int'(e.ok));
          if (e.ok) begin
            m_id = e.id; m_x = e.x; m_y = e.y;
          end
        end
      end
      chk("cmd_id", int'(bus.cmd_id), m_id);
      chk("x", int'(bus.x), m_x);
      chk("y", int'(bus.y), m_y);
    end
  end

  // -------------------------------------------------- directed sequence
  int sv_v, sv_e, sv_f, sv_b;

  task automatic mark();
    sv_v = n_valid; sv_e = n_err; sv_f = n_fe; sv_b = n_bytes;
  endtask

  task automatic expect_pulses(string tag, int dv, int de, int df);
    chk({tag, "_valid_count"}, n_valid - sv_v, dv);
    chk({tag, "_err_count"}, n_err - sv_e, de);
    chk({tag, "_frame_count"}, n_fe - sv_f, df);
  endtask

  task automatic expect_regs(string tag, int id, int xv, int yv);
    chk({tag, "_cmd_id"}, int'(bus.cmd_id), id);
    chk({tag, "_x"}, int'(bus.x), xv);
    chk({tag, "_y"}, int'(bus.y), yv);
  endtask

  initial begin
    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_byte", int'(bus.rx_byte), 0);
    chk("reset_rx_byte_valid", int'(bus.rx_byte_valid), 0);
    chk("reset_frame_err", int'(bus.frame_err), 0);
    chk("reset_cmd_valid", int'(bus.cmd_valid), 0);
    chk("reset_cmd_err", int'(bus.cmd_err), 0);
    expect_regs("reset", 0, 0, 0);
    repeat (2 * CPB) @(negedge clk);

    mark();
    send_line("UP,12,4", 3);
    expect_pulses("up_crlf", 1, 0, 0);
    expect_regs("up_crlf", 1, 12, 4);

    mark();
    send_line("cl", 2);
    expect_pulses("cl", 1, 0, 0);
    expect_regs("cl", 6, 0, 0);

    mark();
    send_line("PX,128,3", 2);
    expect_pulses("px_overflow", 0, 1, 0);
    expect_regs("px_overflow", 6, 0, 0);

    mark();
    send_line("ZZ,1,1", 2);
    send_line("RT,5,6", 1);
    expect_pulses("zz_rt", 1, 1, 0);
    expect_regs("zz_rt", 4, 5, 6);

    mark();
    send_str("DN,");
    send_byte("3", 1'b1);
    send_line(",9", 2);
    expect_pulses("dn_frame", 0, 1, 1);
    mark();
    send_line("DN,1,2", 2);
    expect_pulses("dn_after", 1, 0, 0);
    expect_regs("dn_after", 2, 1, 2);

    // Reset in the middle of ',' (its first two data bits are 0).
    send_str("CO");
    bus.rx = 1'b0;
    repeat (CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    lbuf.delete();
    line_bad = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_regs("mid_reset", 0, 0, 0);
    mark();
    repeat (4 * CPB) @(negedge clk);
    chk("mid_reset_no_byte", n_bytes - sv_b, 0);
    expect_pulses("mid_reset_quiet", 0, 0, 0);
    bus.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    mark();
    send_line("CO,7,7", 2);
    expect_pulses("co", 1, 0, 0);
    expect_regs("co", 7, 7, 7);

    for (int n = 0; n < 30; n++) send_random_line();

    repeat (4 * CPB) @(negedge clk);
    chk("pending_cmd_events", exp_ev.size(), 0);
    chk("pending_rx_bytes", exp_byte.size(), 0);
    chk("pending_frame_errs", exp_fe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
- Parametrised successor to the keyboard/Bluetooth command receiver: one module containing the UART byte receiver and an ASCII line parser.
- Turns lines of the form "CC,X,Y<term>" from the Bluetooth module into command pulses for the paint core.
- Beyond the previous receiver, it adds:
  - generic baud rate and coordinate width;
  - CR, LF or CRLF line terminators;
  - an argument-less command form;
  - explicit error reporting (framing, syntax, unknown command, overflow).

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated.
- COORD_W, 7, width of the x and y outputs.
- MAX_DIGITS, 3, maximum decimal digits per coordinate field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rx  in  1  UART line from the Bluetooth module; idle high.
- rx_byte  out  8  last received byte (debug).
- rx_byte_valid  out  1  1-cycle pulse when rx_byte updates.
- frame_err  out  1  1-cycle pulse when a stop bit is sampled low.
- cmd_valid  out  1  1-cycle pulse: a well-formed command was accepted.
- cmd_err  out  1  1-cycle pulse: a non-empty line was rejected.
- cmd_id  out  4  command code; holds the last valid value.
- x  out  COORD_W  X argument; holds the last valid value.
- y  out  COORD_W  Y argument; holds the last valid value.

Behaviour:
- Reset: all outputs are 0. UART goes to U_IDLE, parser to P_IDLE, accumulators are cleared.
  - rst is asserted asynchronously and released synchronously to clk.
- rx synchroniser: rx passes through 2 flip-flops before use.
- Armed flag: after reset or a framing error, the receiver detects no start bit until the synchronised rx has been sampled high at least once. This prevents false starts mid-byte.
- UART FSM:
  - U_IDLE: a falling edge while armed moves to U_START.
  - U_START: wait CLKS_PER_BIT/2 cycles, then resample rx. Low moves to U_DATA; high is a glitch and returns to U_IDLE.
  - U_DATA: 8 bits, LSB first, each sampled every CLKS_PER_BIT cycles.
  - U_STOP: sample once more.
    - High: rx_byte and rx_byte_valid update on the same edge.
    - Low: pulse frame_err, drop the byte, mark the current line bad (parser goes to P_SKIP), clear armed.
- Parser input:
  - Consumes one byte per rx_byte_valid, registered.
  - Lowercase letters are folded to uppercase.
  - A terminator is 0x0D or 0x0A.
- Parser FSM (any byte not listed for a state goes to P_SKIP):
  - P_IDLE: terminator stays in P_IDLE with no pulse (empty line; this is how CRLF is absorbed). Letter: store c0, go to P_CMD1.
  - P_CMD1: letter: store c1, go to P_CMDEND.
  - P_CMDEND: ',' clears acc and ndig, goes to P_X. Terminator emits with x=y=0.
  - P_X: digit goes to acc. ',' with ndig ≥ 1 latches xa and goes to P_Y. A terminator in P_X is an error.
  - P_Y: digit goes to acc. Terminator with ndig ≥ 1 emits with y=acc.
  - P_SKIP: discard bytes until a terminator, then pulse cmd_err and go to P_IDLE.
- Digit arithmetic: acc ← acc*10 + digit, in COORD_W+4 bits.
  - acc > 2^COORD_W−1 is an error, checked on every digit.
  - ndig > MAX_DIGITS is an error.
- Command table: UP=1, DN=2, LT=3, RT=4, PX=5, CL=6, CO=7. Any other mnemonic is an error, reported at its terminator.
- Emit: on the clk edge after the terminator's rx_byte_valid, cmd_valid=1 for one cycle. cmd_id, x and y update on that same edge and hold afterwards.
  - Error lines pulse cmd_err on that same edge instead. cmd_id, x and y remain unchanged.
- cmd_valid and cmd_err are never asserted together.
- Line length is unbounded; P_SKIP absorbs any number of bytes.
- Async reset mid-byte or mid-line: the partial byte and partial line are discarded, with no pulse.

Test Plan:
- Send "UP,12,4",0x0D,0x0A (CLKS_PER_BIT=5208) → one cmd_valid; cmd_id=1, x=12, y=4; no cmd_err; the LF produces no pulse.
- Send "cl",0x0A → cmd_valid; cmd_id=6, x=0, y=0.
- Send "PX,128,3",0x0A with COORD_W=7 → cmd_err pulse, no cmd_valid; cmd_id, x and y keep their previous values.
- Send "ZZ,1,1",0x0A, then "RT,5,6",0x0D → cmd_err for the first line; cmd_valid with cmd_id=4, x=5, y=6 for the second.
- Send "DN,3" with the stop bit of '3' forced low, then ",9",0x0A → frame_err pulse, then cmd_err at the LF. Next "DN,1,2",0x0A → cmd_valid, cmd_id=2.
- Assert rst in the middle of the data bits of ',' in "CO,7,7" and release with rx low → no start is detected until rx is high. A following "CO,7,7",0x0A → cmd_valid with cmd_id=7, x=7, y=7.
